mmio_arbiter_fsm: RTL and testbench
===================================

Name: mmio_arbiter_fsm

Overview:
- Two-master arbiter and sequencer in front of the single shared memory/MMIO port; the handshake is valid_mem-based.
- Fetch port (read-only) and data port (read/write) each present level requests and receive a stall signal.
- The arbiter latches the winning request, holds it on the memory port until valid_mem, then returns registered read data with one completion cycle.
- A round-robin tie-break prevents starvation. An optional timeout watchdog completes hung accesses and flags an error.

Parameters:
- TIMEOUT, 255, max BUSY cycles waiting for valid_mem before forced completion; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- if_address  in  64  fetch address
- if_ren  in  1  fetch request, held until if_stall low
- if_rdata  out  64  fetch read data, valid in fetch DONE cycle
- if_stall  out  1  fetch stall
- d_address  in  64  data address
- d_ren  in  1  data read request
- d_wen  in  1  data write request
- d_wdata  in  64  data write data
- d_wmask  in  8  data byte mask
- d_rdata  out  64  data read data, valid in data DONE cycle
- d_stall  out  1  data stall
- address_mem  out  64  shared-port address
- ren_mem  out  1  shared-port read
- wen_mem  out  1  shared-port write
- wmask_mem  out  8  shared-port mask
- wdata_mem  out  64  shared-port write data
- rdata_mem  in  64  shared-port read data
- valid_mem  in  1  shared-port completion
- bus_err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY, DONE. A registered owner bit (0=fetch, 1=data) qualifies BUSY and DONE. A last bit records the most recently granted master.
- Reset (async, rstn=0):
  - state=IDLE, owner=0, last=0 (fetch), counter=0, bus_err=0.
  - All latched address/wdata/wmask/ren/wen registers and if_rdata/d_rdata are 0.
  - The memory port deasserts immediately. Reset mid-BUSY abandons the access with no completion.
- IDLE:
  - Only one master requesting: grant it.
  - Both requesting: grant the master not equal to last. After reset this grants data first.
  - On grant: latch that master's address, wdata, wmask, ren and wen (fetch forces wen=0, wmask=0, wdata=0); set owner and last; clear counter; go to BUSY.
  - No request: stay in IDLE.
- d_ren and d_wen both high: treated as a write; the latched ren is 0.
- BUSY:
  - Memory port is driven from latched registers only; input changes are ignored. The port is all-zero outside BUSY.
  - valid_mem=1: capture rdata_mem into the owner's rdata register (writes capture as well), then go to DONE.
  - Otherwise, if TIMEOUT≠0 and counter==TIMEOUT-1: load 0 into the owner's rdata, set bus_err, go to DONE. Else increment counter.
  - valid_mem on the timeout cycle takes priority over the timeout.
- DONE: lasts exactly one cycle, then IDLE. The non-owner rdata register holds its prior value.
- Stalls:
  - if_stall = if_ren & ~(DONE & owner==0).
  - d_stall = (d_ren|d_wen) & ~(DONE & owner==1).
  - Stalls are combinational and low when the master is not requesting.
- valid_mem outside BUSY is ignored.
- Latency: request seen in IDLE cycle N; memory port active N+1; valid_mem at N+k (k≥1); DONE at N+k+1. Minimum 3 cycles per access.

Test Plan:
- Single fetch: if_ren=1, if_address=0x80200000; valid_mem in the 1st BUSY cycle with rdata_mem=0x00000013_00000093 → address_mem=0x80200000 and ren_mem=1 for 1 cycle; if_rdata=0x00000013_00000093 and if_stall=0 in the next cycle; total 3 cycles.
- Data write: d_wen=1, d_address=0x10000000, d_wdata=0x41, d_wmask=0x01; valid_mem after 4 BUSY cycles → wen_mem=1 held 4 cycles with stable latched fields; d_stall low in exactly 1 cycle.
- Contention: if_ren and d_ren held high from reset release → grants alternate data, fetch, data, fetch; neither master waits for two consecutive opposite grants.
- Input change mid-BUSY: alter d_address from 0x100 to 0x200 during BUSY → address_mem stays 0x100 until DONE.
- Timeout, TIMEOUT=4: valid_mem never asserted → DONE after 4 BUSY cycles; d_rdata=0; bus_err=1 and stays 1 across subsequent successful accesses.
- Reset mid-BUSY: drop rstn during BUSY → ren_mem, wen_mem and both stalls' internal grant clear immediately; after release, state is IDLE and bus_err=0.

Source files
------------

// File: rtl/mmio_arbiter_fsm.sv
// Two-master (fetch / data) arbiter in front of one shared memory/MMIO port.
// Round-robin on contention, one access in flight, optional timeout watchdog.
module mmio_arbiter_fsm #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  // fetch master (read-only)
  input  logic [63:0] if_address,
  input  logic        if_ren,
  output logic [63:0] if_rdata,
  output logic        if_stall,
  // data master (read/write)
  input  logic [63:0] d_address,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wmask,
  output logic [63:0] d_rdata,
  output logic        d_stall,
  // shared memory port
  output logic [63:0] address_mem,
  output logic        ren_mem,
  output logic        wen_mem,
  output logic [7:0]  wmask_mem,
  output logic [63:0] wdata_mem,
  input  logic [63:0] rdata_mem,
  input  logic        valid_mem,
  output logic        bus_err,
  // debug view: state encoding 0=IDLE 1=BUSY 2=DONE, owner 0=fetch 1=data
  output logic [1:0]  dbg_state,
  output logic        dbg_owner
);

  // Handshake: a master holds its request level until its stall drops; stall
  // is low for exactly the single DONE cycle of that master's access. On the
  // memory side the latched request is held in BUSY until valid_mem is seen.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               WDOG_EN  = (TIMEOUT != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_owner;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
  logic [63:0]      r_addr;
  logic [63:0]      r_wdata;
  logic [7:0]       r_wmask;
  logic             r_ren;
  logic             r_wen;
  logic [63:0]      r_if_rdata;
  logic [63:0]      r_d_rdata;

  logic w_if_req;
  logic w_d_req;
  logic w_grant;
  logic w_grant_data;
  logic w_timeout;
  logic w_busy;
  logic w_done;

  assign w_if_req = if_ren;
  assign w_d_req  = d_ren | d_wen;
  assign w_busy   = (r_state == S_BUSY);
  assign w_done   = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_grant_data = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_if_req || w_d_req) begin
          w_grant = 1'b1;
          // on contention the master that did not win last time goes first
          w_grant_data = w_d_req && (!w_if_req || !r_last);
          w_state_nxt  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (valid_mem) begin
          w_state_nxt = S_DONE;
        end else if (WDOG_EN && (r_cnt == CNT_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_owner    <= 1'b0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_ren      <= 1'b0;
      r_wen      <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_data;
        r_last  <= w_grant_data;
        r_cnt   <= '0;
        if (w_grant_data) begin
          r_addr  <= d_address;
          r_wdata <= d_wdata;
          r_wmask <= d_wmask;
          r_wen   <= d_wen;
          // read+write together is issued as a write
          r_ren   <= d_ren & ~d_wen;
        end else begin
          r_addr  <= if_address;
          r_wdata <= '0;
          r_wmask <= '0;
          r_wen   <= 1'b0;
          r_ren   <= 1'b1;
        end
      end
      if (w_busy) begin
        if (valid_mem) begin
          if (r_owner) begin
            r_d_rdata <= rdata_mem;
          end else begin
            r_if_rdata <= rdata_mem;
          end
        end else if (w_timeout) begin
          if (r_owner) begin
            r_d_rdata <= '0;
          end else begin
            r_if_rdata <= '0;
          end
          r_bus_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // memory port shows only latched fields, and only while BUSY
  assign address_mem = w_busy ? r_addr  : '0;
  assign wdata_mem   = w_busy ? r_wdata : '0;
  assign wmask_mem   = w_busy ? r_wmask : '0;
  assign ren_mem     = w_busy & r_ren;
  assign wen_mem     = w_busy & r_wen;

  assign if_stall = w_if_req & ~(w_done & ~r_owner);
  assign d_stall  = w_d_req  & ~(w_done &  r_owner);

  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign bus_err   = r_bus_err;
  assign dbg_state = r_state;
  assign dbg_owner = r_owner;

endmodule

// File: tb/tb_mmio_arbiter_fsm.sv
// Randomized bench for mmio_arbiter_fsm: two master drivers, a transaction
// level memory/reference model, and monitors that pop expected results.
module tb_mmio_arbiter_fsm;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;
  localparam int N_TXN   = 40;
  localparam int ACC_W   = 138;  // {ren, wen, wmask[8], wdata[64], addr[64]}
  localparam int EXP_W   = 130;  // {err, owner, if_rdata[64], d_rdata[64]}

  logic        clk;
  logic        rstn;
  logic [63:0] if_address;
  logic        if_ren;
  logic [63:0] if_rdata;
  logic        if_stall;
  logic [63:0] d_address;
  logic        d_ren;
  logic        d_wen;
  logic [63:0] d_wdata;
  logic [7:0]  d_wmask;
  logic [63:0] d_rdata;
  logic        d_stall;
  logic [63:0] address_mem;
  logic        ren_mem;
  logic        wen_mem;
  logic [7:0]  wmask_mem;
  logic [63:0] wdata_mem;
  logic [63:0] rdata_mem = 64'h0;
  logic        valid_mem = 1'b0;
  logic        bus_err;
  logic [1:0]  dbg_state;
  logic        dbg_owner;

  logic [ACC_W-1:0] acc_q[$];
  logic [EXP_W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int force_lat = 0;

  mmio_arbiter_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .if_address(if_address), .if_ren(if_ren), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_address(d_address), .d_ren(d_ren), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_stall(d_stall),
    .address_mem(address_mem), .ren_mem(ren_mem), .wen_mem(wen_mem),
    .wmask_mem(wmask_mem), .wdata_mem(wdata_mem), .rdata_mem(rdata_mem),
    .valid_mem(valid_mem), .bus_err(bus_err),
    .dbg_state(dbg_state), .dbg_owner(dbg_owner)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, got running required done");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model + memory responder ----------------
  // Transaction view: a grant is decided from the requests visible in an idle
  // cycle, the access then occupies the port for lat cycles (or TIMEOUT cycles
  // if the memory never answers), and the result appears one cycle later.
  bit          m_in_access = 1'b0;
  bit          m_result_cycle = 1'b0;
  bit          m_owner_data = 1'b0;
  bit          m_last_data = 1'b0;
  bit          m_err = 1'b0;
  int          m_cycle = 0;
  int          m_lat = 0;
  logic [63:0] m_if_rdata = 64'h0;
  logic [63:0] m_d_rdata = 64'h0;
  bit          m_f;
  bit          m_d;

  always @(negedge clk) begin
    if (!rstn) begin
      m_in_access = 1'b0; m_result_cycle = 1'b0; m_last_data = 1'b0; m_err = 1'b0;
      m_if_rdata = 64'h0; m_d_rdata = 64'h0;
      acc_q.delete(); exp_q.delete();
      valid_mem = 1'b0;
    end else if (m_result_cycle) begin
      m_result_cycle = 1'b0;
      valid_mem = 1'($urandom_range(0, 1));
      rdata_mem = rand64();
    end else if (m_in_access) begin
      m_cycle++;
      rdata_mem = rand64();
      valid_mem = (m_cycle == m_lat);
      if (valid_mem || m_cycle == TIMEOUT) begin
        if (valid_mem) begin
          if (m_owner_data) m_d_rdata = rdata_mem; else m_if_rdata = rdata_mem;
        end else begin
          if (m_owner_data) m_d_rdata = 64'h0; else m_if_rdata = 64'h0;
          m_err = 1'b1;
        end
        exp_q.push_back({m_err, m_owner_data, m_if_rdata, m_d_rdata});
        m_in_access = 1'b0;
        m_result_cycle = 1'b1;
      end
    end else begin
      valid_mem = 1'($urandom_range(0, 1));
      rdata_mem = rand64();
      m_f = if_ren;
      m_d = d_ren | d_wen;
      if (m_f || m_d) begin
        m_owner_data = (m_f && m_d) ? !m_last_data : m_d;
        m_last_data = m_owner_data;
        if (m_owner_data)
          acc_q.push_back({d_ren & ~d_wen, d_wen, d_wmask, d_wdata, d_address});
        else
          acc_q.push_back({1'b1, 1'b0, 8'h00, 64'h0, if_address});
        m_lat = (force_lat != 0) ? force_lat : $urandom_range(1, TIMEOUT + 2);
        m_cycle = 0;
        m_in_access = 1'b1;
      end
    end
  end

  // ---------------- scoreboard: memory port monitor ----------------
  logic [ACC_W-1:0] cur_acc;
  bit prev_active = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_active = 1'b0;
    end else if (ren_mem || wen_mem) begin
      if (!prev_active) begin
        if (acc_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL port_grant: got access at %0h required no access", address_mem);
          cur_acc = {ren_mem, wen_mem, wmask_mem, wdata_mem, address_mem};
        end else begin
          cur_acc = acc_q.pop_front();
        end
      end
      check("ren_mem", 64'(ren_mem), 64'(cur_acc[137]));
      check("wen_mem", 64'(wen_mem), 64'(cur_acc[136]));
      check("wmask_mem", 64'(wmask_mem), 64'(cur_acc[135:128]));
      check("wdata_mem", wdata_mem, cur_acc[127:64]);
      check("address_mem", address_mem, cur_acc[63:0]);
      prev_active = 1'b1;
    end else begin
      check("port_idle_zero", address_mem | wdata_mem | {56'h0, wmask_mem}, 64'h0);
      prev_active = 1'b0;
    end
  end

  // ---------------- scoreboard: completion monitor ----------------
  task automatic complete(input bit is_data);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL done_unexpected: got completion for master %0d required none", is_data);
      return;
    end
    e = exp_q.pop_front();
    check("done_owner", 64'(is_data), 64'(e[128]));
    check("if_rdata", if_rdata, e[127:64]);
    check("d_rdata", d_rdata, e[63:0]);
    check("bus_err", 64'(bus_err), 64'(e[129]));
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (if_ren && !if_stall) complete(1'b0);
      if ((d_ren || d_wen) && !d_stall) complete(1'b1);
      if (!if_ren) check("if_stall_no_req", 64'(if_stall), 64'h0);
      if (!(d_ren || d_wen)) check("d_stall_no_req", 64'(d_stall), 64'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fetch_driver(input int n);
    int  waited;
    bit  done;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      int gap = (i == 0) ? 0 : $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
      if_ren = 1'b1;
      if_address = rand64();
      waited = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (!if_stall) begin
          done = 1'b1;
        end else if (++waited > 100) begin
          tests++; fails++;
          $display("FAIL fetch_wait: got stall after %0d cycles required completion", waited);
          if_ren = 1'b0;
          return;
        end else begin
          @(posedge clk); #1;
          if ($urandom_range(0, 3) == 0) if_address = rand64();
        end
      end
      @(posedge clk); #1;
      if_ren = 1'b0;
      if_address = rand64();
    end
  endtask

  task automatic data_req(input int kind);
    d_ren = (kind != 1);
    d_wen = (kind != 0);
    d_address = rand64();
    d_wdata = rand64();
    d_wmask = 8'($urandom);
  endtask

  task automatic data_wait(output bit ok);
    int waited = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      if (!d_stall) begin
        ok = 1'b1;
      end else if (++waited > 100) begin
        tests++; fails++;
        $display("FAIL data_wait: got stall after %0d cycles required completion", waited);
        d_ren = 1'b0; d_wen = 1'b0;
        return;
      end else begin
        @(posedge clk); #1;
        if ($urandom_range(0, 2) == 0) d_address = rand64();
        if ($urandom_range(0, 2) == 0) d_wdata = rand64();
      end
    end
    @(posedge clk); #1;
    d_ren = 1'b0; d_wen = 1'b0;
  endtask

  task automatic data_driver(input int n);
    bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      int gap = (i == 0) ? 0 : $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
      data_req($urandom_range(0, 2));
      data_wait(ok);
      if (!ok) return;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int waited;
    rstn = 1'b0;
    if_ren = 1'b0; if_address = 64'h0;
    d_ren = 1'b0; d_wen = 1'b0; d_address = 64'h0; d_wdata = 64'h0; d_wmask = 8'h0;
    #2;
    check("rst_if_rdata", if_rdata, 64'h0);
    check("rst_d_rdata", d_rdata, 64'h0);
    check("rst_port", address_mem | wdata_mem | {56'h0, wmask_mem}, 64'h0);
    check("rst_ren_wen", {62'h0, ren_mem, wen_mem}, 64'h0);
    check("rst_bus_err", 64'(bus_err), 64'h0);
    check("rst_state", 64'(dbg_state), 64'h0);
    check("rst_stalls", {62'h0, if_stall, d_stall}, 64'h0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    // both masters start together right after reset: data must win first
    fork
      fetch_driver(N_TXN);
      data_driver(N_TXN);
    join

    // memory never answers: forced completion with zero data and error
    force_lat = TIMEOUT + 2;
    @(posedge clk); #1;
    data_req(0);
    data_wait(ok);
    repeat (2) @(negedge clk);
    check("acc_q_drained", 64'(acc_q.size()), 64'h0);
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    check("bus_err_sticky", 64'(bus_err), 64'h1);

    // reset in the middle of a write
    @(posedge clk); #1;
    d_ren = 1'b0; d_wen = 1'b1; d_address = 64'h100; d_wdata = 64'h41; d_wmask = 8'h01;
    waited = 0;
    @(negedge clk);
    while (!wen_mem && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("busy_reached", 64'(wen_mem), 64'h1);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_ren", 64'(ren_mem), 64'h0);
    check("rst_mid_wen", 64'(wen_mem), 64'h0);
    check("rst_mid_addr", address_mem, 64'h0);
    check("rst_mid_d_stall", 64'(d_stall), 64'h1);
    check("rst_mid_bus_err", 64'(bus_err), 64'h0);
    check("rst_mid_d_rdata", d_rdata, 64'h0);
    d_wen = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("post_rst_state", 64'(dbg_state), 64'h0);
    check("post_rst_bus_err", 64'(bus_err), 64'h0);
    check("post_rst_port", {62'h0, ren_mem, wen_mem}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
